command_register_bank: RTL and testbench
========================================

// Module: command_register_bank
// PURPOSE
//  Register-bank responder for the command manager's register-access handshake (registersData side).
//  Services write_register/read_register requests addressed by command; data comes from rx_data.
//  Holds the DAQ configuration registers, exposes them flat to the datapath, returns read data.
//  Sits between the command manager and the sigma-delta datapath configuration inputs.
// PARAMETERS
//  DATA_LENGTH    32           register/data width
//  COMMAND_WIDTH  5            address (command) width
//  NUM_REGS       16           implemented addresses 0..NUM_REGS-1, 4 <= NUM_REGS <= 2**COMMAND_WIDTH
//  VERSION_ID     32'h0001_0000  constant returned at address 0
// PORTS
//  clk                 in   1                       clock, all logic rising-edge
//  reset               in   1                       synchronous, active-high
//  write_register      in   1                       write request, level, held until ack seen
//  read_register       in   1                       read request, level, held until ack seen
//  command             in   COMMAND_WIDTH           register address, valid while a request is high
//  rx_data             in   DATA_LENGTH             write data, valid while write_register high
//  status_in           in   DATA_LENGTH             live datapath status, readable at address 1
//  write_register_ack  out  1                       write acknowledge
//  read_register_ack   out  1                       read acknowledge
//  reg_data            out  DATA_LENGTH             read data, valid while read_register_ack high
//  reg_out             out  NUM_REGS*DATA_LENGTH    flat register contents, reg i at [i*DATA_LENGTH +: DATA_LENGTH]
//  addr_error          out  1                       sticky illegal-access flag
// BEHAVIOUR
//  Clock clk; reset synchronous, active-high.
//  Map: 0 = VERSION_ID (RO); 1 = status_in (RO, sampled at read accept); 2 = write counter (RO);
//   3..NUM_REGS-1 = RW config, reset 0. reg_out slices 0/1/2 carry ID/status_in/counter.
//  Reset: FSM=IDLE, both acks 0, reg_data 0, addr_error 0, counter 0, RW regs 0. Reset mid-handshake
//   aborts: acks 0 at next edge, no write committed at that edge.
//  FSM states IDLE, WR_ACK, RD_ACK (four-phase handshake):
//   IDLE: write_register=1 at edge N -> commit (if legal), write_register_ack=1 after edge N, -> WR_ACK.
//         else read_register=1 at edge N -> reg_data loaded, read_register_ack=1 after edge N, -> RD_ACK.
//         Both high: write wins; read serviced after write completes if still high.
//   WR_ACK: ack held 1 while write_register=1; write_register=0 at edge M -> ack 0 after M, -> IDLE.
//   RD_ACK: same with read_register; reg_data frozen from accept until next read accept.
//  Latency: request to ack = 1 cycle; ack drop = 1 cycle after request drop; min 3 cycles/transaction.
//  Exactly one commit per handshake regardless of request hold time; command/rx_data sampled at accept only.
//  Legal write: address 3..NUM_REGS-1 -> register <= rx_data, counter +1 (wraps 2**DATA_LENGTH-1 -> 0),
//   addr_error cleared.
//  Illegal write (address 0..2 or >= NUM_REGS): acked normally, no register change, counter unchanged,
//   addr_error <= 1.
//  Read >= NUM_REGS: acked, reg_data = 0, addr_error <= 1. Legal reads leave addr_error unchanged.
//  New request not accepted until FSM back in IDLE.
// TESTING
//  1 reset, read addr 0 -> ack 1 cycle after req, reg_data=32'h0001_0000; acks/addr_error 0 after reset.
//  2 write addr 4 = 32'hA5A5_1234 -> ack next cycle, reg_out[4]=A5A5_1234, read 4 and read 2 return A5A5_1234 and 1.
//  3 write addr 0 = 32'hFFFF_FFFF -> acked, addr 0 still 0001_0000, addr_error=1; write addr 3 -> addr_error=0.
//  4 write and read addr 5 raised same cycle, wdata 32'h0000_00C3 -> write acked first, then read returns 0000_00C3.
//  5 write_register held 10 cycles on addr 6 -> ack high 9 cycles, one commit, counter +1 only.
//  6 reset pulse while in WR_ACK with reg 7=32'h1234 -> acks 0 next edge, reg 7=0, counter 0, FSM IDLE.

Source files
------------

// File: rtl/command_register_bank.sv
// DAQ config register bank on a four-phase write/read handshake; request-to-ack 1 cycle, ack drops 1 cycle after request.
// Backpressure: one transaction at a time; new requests wait until the FSM is back in IDLE.
module command_register_bank #(
  parameter int                      DATA_LENGTH   = 32,
  parameter int                      COMMAND_WIDTH = 5,
  parameter int                      NUM_REGS      = 16,
  parameter logic [DATA_LENGTH-1:0]  VERSION_ID    = 32'h0001_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write_register,
  input  logic                            read_register,
  input  logic [COMMAND_WIDTH-1:0]        command,
  input  logic [DATA_LENGTH-1:0]          rx_data,
  input  logic [DATA_LENGTH-1:0]          status_in,
  output logic                            write_register_ack,
  output logic                            read_register_ack,
  output logic [DATA_LENGTH-1:0]          reg_data,
  output logic [NUM_REGS*DATA_LENGTH-1:0] reg_out,
  output logic                            addr_error
);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_ACK} state_t;

  state_t                 state_q, state_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   rd_ack_q, rd_ack_d;
  logic                   addr_error_q, addr_error_d;
  logic [DATA_LENGTH-1:0] reg_data_q, reg_data_d;
  logic [DATA_LENGTH-1:0] wcnt_q, wcnt_d;
  logic [DATA_LENGTH-1:0] cfg_q [3:NUM_REGS-1];
  logic [DATA_LENGTH-1:0] cfg_d [3:NUM_REGS-1];

  logic [31:0]            addr;
  logic                   in_range;
  logic                   legal_wr;
  logic [DATA_LENGTH-1:0] rd_mux;

  // Address decode and read mux; out-of-range reads return zero.
  always_comb begin
    addr     = 32'(command);
    in_range = (addr < 32'(NUM_REGS));
    legal_wr = in_range && (addr >= 32'd3);
    rd_mux   = '0;
    if (addr == 32'd0)      rd_mux = VERSION_ID;
    else if (addr == 32'd1) rd_mux = status_in;
    else if (addr == 32'd2) rd_mux = wcnt_q;
    else begin
      for (int i = 3; i < NUM_REGS; i++) begin
        if (addr == 32'(i)) rd_mux = cfg_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ack_d     = wr_ack_q;
    rd_ack_d     = rd_ack_q;
    addr_error_d = addr_error_q;
    reg_data_d   = reg_data_q;
    wcnt_d       = wcnt_q;
    cfg_d        = cfg_q;
    case (state_q)
      IDLE: begin
        // Write has priority; a concurrent read is picked up once the write handshake closes.
        if (write_register) begin
          state_d  = WR_ACK;
          wr_ack_d = 1'b1;
          if (legal_wr) begin
            for (int i = 3; i < NUM_REGS; i++) begin
              if (addr == 32'(i)) cfg_d[i] = rx_data;
            end
            wcnt_d       = wcnt_q + DATA_LENGTH'(1);
            addr_error_d = 1'b0;
          end else begin
            addr_error_d = 1'b1;
          end
        end else if (read_register) begin
          state_d    = RD_ACK;
          rd_ack_d   = 1'b1;
          reg_data_d = rd_mux;
          if (!in_range) addr_error_d = 1'b1;
        end
      end
      WR_ACK: begin
        if (!write_register) begin
          state_d  = IDLE;
          wr_ack_d = 1'b0;
        end
      end
      RD_ACK: begin
        if (!read_register) begin
          state_d  = IDLE;
          rd_ack_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ack_d = 1'b0;
        rd_ack_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      addr_error_q <= 1'b0;
      reg_data_q   <= '0;
      wcnt_q       <= '0;
      for (int i = 3; i < NUM_REGS; i++) cfg_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      addr_error_q <= addr_error_d;
      reg_data_q   <= reg_data_d;
      wcnt_q       <= wcnt_d;
      cfg_q        <= cfg_d;
    end
  end

  always_comb begin
    reg_out                            = '0;
    reg_out[0*DATA_LENGTH +: DATA_LENGTH] = VERSION_ID;
    reg_out[1*DATA_LENGTH +: DATA_LENGTH] = status_in;
    reg_out[2*DATA_LENGTH +: DATA_LENGTH] = wcnt_q;
    for (int i = 3; i < NUM_REGS; i++) begin
      reg_out[i*DATA_LENGTH +: DATA_LENGTH] = cfg_q[i];
    end
  end

  assign write_register_ack = wr_ack_q;
  assign read_register_ack  = rd_ack_q;
  assign reg_data           = reg_data_q;
  assign addr_error         = addr_error_q;

endmodule

// File: tb/tb_command_register_bank.sv
// Bench for command_register_bank: scenario tasks drive handshakes, expected read data queued at request time.
module tb_command_register_bank;

  localparam int DL = 32;
  localparam int CW = 5;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_register, read_register;
  logic [CW-1:0] command;
  logic [DL-1:0] rx_data, status_in;
  logic          write_register_ack, read_register_ack;
  logic [DL-1:0] reg_data;
  logic [NR*DL-1:0] reg_out;
  logic          addr_error;

  int tests_run = 0;
  int fails     = 0;
  logic [DL-1:0] exp_q [$];
  logic [DL-1:0] exp_cnt;

  always #5 clk = ~clk;

  command_register_bank #(.DATA_LENGTH(DL), .COMMAND_WIDTH(CW), .NUM_REGS(NR),
                          .VERSION_ID(32'h0001_0000)) dut (
    .clk(clk), .reset(reset),
    .write_register(write_register), .read_register(read_register),
    .command(command), .rx_data(rx_data), .status_in(status_in),
    .write_register_ack(write_register_ack), .read_register_ack(read_register_ack),
    .reg_data(reg_data), .reg_out(reg_out), .addr_error(addr_error)
  );

  // Full write handshake; lat = cycles until ack, 99 if ack never rose or never dropped.
  task automatic do_write(input logic [CW-1:0] a, input logic [DL-1:0] d, output int lat);
    command = a; rx_data = d; write_register = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!write_register_ack && lat < 20);
    if (!write_register_ack) lat = 99;
    write_register = 1'b0;
    for (int k = 0; k < 20 && write_register_ack; k++) begin @(posedge clk); #1; end
    if (write_register_ack) lat = 99;
    if (a >= 5'd3 && a < 5'(NR) && lat != 99) exp_cnt = exp_cnt + 1;
  endtask

  task automatic do_read(input logic [CW-1:0] a, output logic [DL-1:0] d, output int lat);
    command = a; read_register = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!read_register_ack && lat < 20);
    if (!read_register_ack) lat = 99;
    d = reg_data;
    read_register = 1'b0;
    for (int k = 0; k < 20 && read_register_ack; k++) begin @(posedge clk); #1; end
    if (read_register_ack) lat = 99;
  endtask

  task automatic test_reset;
    logic [DL-1:0] d, e; int lat;
    reset = 1'b1; write_register = 0; read_register = 0; command = '0; rx_data = '0;
    status_in = 32'hDEAD_BEEF; exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests_run++; if ({write_register_ack, read_register_ack, addr_error} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {write_register_ack, read_register_ack, addr_error}); end
    tests_run++; if (reg_data !== 32'h0) begin
      fails++; $display("FAIL reset_reg_data got=%h exp=0", reg_data); end
    tests_run++; if (reg_out[4*DL +: DL] !== 32'h0) begin
      fails++; $display("FAIL reset_reg4 got=%h exp=0", reg_out[4*DL +: DL]); end
    exp_q.push_back(32'h0001_0000);
    do_read(5'd0, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== 1) begin fails++; $display("FAIL read0_latency got=%0d exp=1", lat); end
    tests_run++; if (d !== e) begin fails++; $display("FAIL read0_data got=%h exp=%h", d, e); end
  endtask

  task automatic test_write_read;
    logic [DL-1:0] d, e; int lat;
    do_write(5'd4, 32'hA5A5_1234, lat);
    tests_run++; if (lat !== 1) begin fails++; $display("FAIL wr4_latency got=%0d exp=1", lat); end
    tests_run++; if (reg_out[4*DL +: DL] !== 32'hA5A5_1234) begin
      fails++; $display("FAIL wr4_reg_out got=%h exp=a5a51234", reg_out[4*DL +: DL]); end
    exp_q.push_back(32'hA5A5_1234);
    do_read(5'd4, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL rd4_data got=%h exp=%h", d, e); end
    exp_q.push_back(exp_cnt);
    do_read(5'd2, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (d !== e || e !== 32'd1) begin fails++; $display("FAIL rd_counter got=%h exp=%h", d, 32'd1); end
  endtask

  task automatic test_status;
    logic [DL-1:0] d, e; int lat;
    exp_q.push_back(status_in);
    do_read(5'd1, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL rd_status got=%h exp=%h", d, e); end
    status_in = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (reg_data !== e) begin fails++; $display("FAIL reg_data_frozen got=%h exp=%h", reg_data, e); end
  endtask

  task automatic test_illegal;
    logic [DL-1:0] d, e; int lat;
    do_write(5'd0, 32'hFFFF_FFFF, lat);
    tests_run++; if (addr_error !== 1'b1) begin fails++; $display("FAIL wr0_addr_error got=%b exp=1", addr_error); end
    exp_q.push_back(32'h0001_0000);
    do_read(5'd0, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL wr0_ro got=%h exp=%h", d, e); end
    do_write(5'd3, 32'h0000_0033, lat);
    tests_run++; if (addr_error !== 1'b0) begin fails++; $display("FAIL wr3_clears_err got=%b exp=0", addr_error); end
    exp_q.push_back(32'h0);
    do_read(5'd20, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== 1 || d !== e) begin fails++; $display("FAIL rd_oob got=%h lat=%0d exp=%h lat=1", d, lat, e); end
    tests_run++; if (addr_error !== 1'b1) begin fails++; $display("FAIL rd_oob_err got=%b exp=1", addr_error); end
  endtask

  task automatic test_back_to_back;
    logic [DL-1:0] e; int n;
    command = 5'd5; rx_data = 32'h0000_00C3;
    exp_q.push_back(32'h0000_00C3);
    write_register = 1'b1; read_register = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ({write_register_ack, read_register_ack} !== 2'b10) begin
      fails++; $display("FAIL both_write_first got=%b exp=10", {write_register_ack, read_register_ack}); end
    exp_cnt = exp_cnt + 1;
    write_register = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!read_register_ack && n < 20);
    e = exp_q.pop_front();
    tests_run++; if (n !== 2 || reg_data !== e) begin
      fails++; $display("FAIL both_read_after got=%h cyc=%0d exp=%h cyc=2", reg_data, n, e); end
    read_register = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_long_hold;
    logic [DL-1:0] d, e; int n, lat;
    command = 5'd6; rx_data = 32'h6666_0006; write_register = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin
      if (write_register_ack) n++;
      @(posedge clk); #1;
    end
    write_register = 1'b0;
    exp_cnt = exp_cnt + 1;
    @(posedge clk); #1;
    tests_run++; if (n !== 9 || write_register_ack !== 1'b0) begin
      fails++; $display("FAIL hold_ack_cycles got=%0d ack=%b exp=9 ack=0", n, write_register_ack); end
    exp_q.push_back(exp_cnt);
    do_read(5'd2, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (d !== e || e !== 32'd4) begin fails++; $display("FAIL hold_one_commit got=%h exp=%h", d, 32'd4); end
  endtask

  task automatic test_reset_mid;
    logic [DL-1:0] d, e; int lat;
    do_write(5'd7, 32'h0000_1234, lat);
    command = 5'd8; rx_data = 32'h0000_0055; write_register = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ({write_register_ack, read_register_ack} !== 2'b00) begin
      fails++; $display("FAIL mid_reset_acks got=%b exp=00", {write_register_ack, read_register_ack}); end
    reset = 1'b0; write_register = 1'b0; exp_cnt = '0;
    @(posedge clk); #1;
    tests_run++; if (reg_out[7*DL +: DL] !== 32'h0 || reg_out[8*DL +: DL] !== 32'h0) begin
      fails++; $display("FAIL mid_reset_regs got=%h/%h exp=0/0", reg_out[7*DL +: DL], reg_out[8*DL +: DL]); end
    exp_q.push_back(exp_cnt);
    do_read(5'd2, d, lat);
    e = exp_q.pop_front();
    tests_run++; if (lat !== 1 || d !== e) begin fails++; $display("FAIL mid_reset_counter got=%h lat=%0d exp=%h lat=1", d, lat, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_status();
    test_illegal();
    test_back_to_back();
    test_long_hold();
    test_reset_mid();
    tests_run++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
